// File: rtl/mips_instr_fetch_if.sv
// Fetch-to-core instruction handshake.
// master = fetch stage, slave = consumer (mips_core).
interface mips_instr_fetch_if;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;

  modport master (
    output instr_out,
    output instr_valid,
    output pc_out,
    input  instr_ready
  );

  modport slave (
    input  instr_out,
    input  instr_valid,
    input  pc_out,
    output instr_ready
  );
endinterface

// File: rtl/mips_instr_fetch.sv
// Sequential instruction fetch from a loadable local memory.
// Optional FETCH_STALL_CNT_EN builds the consumer-stall counter.
module mips_instr_fetch #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  mips_instr_fetch_if.master fetch,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_count
);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    FIN
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   len_in;
  logic [ADDR_W:0]   count;
  logic [31:0]       first_word;
  logic              wr;
  logic              go;
  logic              hs;
  logic              last;

  assign wr     = load_we & ~busy;
  assign go     = start & (state != PRESENT);
  assign hs     = fetch.instr_valid & fetch.instr_ready;
  assign len_in = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign last   = (count + ONE_L) == len;
  assign pc_nxt = pc + ADDR_W'(1);

  // A same-cycle load to word 0 must be visible to the first fetch.
  assign first_word = (wr && load_addr == '0) ? load_data : mem[0];

  assign fetch.pc_out = {{(30-ADDR_W){1'b0}}, pc, 2'b00};

  always_ff @(posedge clk) begin
    if (wr) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      pc                <= '0;
      len               <= '0;
      count             <= '0;
      fetch.instr_out   <= '0;
      fetch.instr_valid <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      unique case (state)
        IDLE, FIN: begin
          if (go) begin
            len   <= len_in;
            count <= '0;
            pc    <= '0;
            if (len_in == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              done              <= 1'b0;
              fetch.instr_out   <= first_word;
              fetch.instr_valid <= 1'b1;
              busy              <= 1'b1;
              state             <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (hs) begin
            if (last) begin
              fetch.instr_valid <= 1'b0;
              busy              <= 1'b0;
              done              <= 1'b1;
              state             <= FIN;
            end else begin
              pc              <= pc_nxt;
              fetch.instr_out <= mem[pc_nxt];
              count           <= count + ONE_L;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || go) begin
      stall_count <= '0;
    end else if (fetch.instr_valid && !fetch.instr_ready
                 && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_mips_instr_fetch.sv
// Directed bench for mips_instr_fetch.
// Per-cycle compare against a transaction-level run model.
module tb_mips_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  prog_len;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        busy;
  logic        done;
  logic [15:0] stall_count;

  mips_instr_fetch_if fif ();

  mips_instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .prog_len    (prog_len),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .fetch       (fif),
    .busy        (busy),
    .done        (done),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  logic [31:0] prog [9] = '{
    32'h00011040, 32'h00642842, 32'h00C740C3,
    32'h012A5A20, 32'h018D7221, 32'h01F08A24,
    32'h0253A225, 32'h02B6BA22, 32'h0319D22B
  };

  // Run model: the program is an index walking 0..len-1 over
  // a shadow of memory; outputs follow from the index.
  logic [31:0] mdl_mem [256];
  bit          m_run;
  bit          m_done;
  int          m_idx;
  int          m_len;
  int          m_stall;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  initial for (int i = 0; i < 256; i++) mdl_mem[i] = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_run = 0; m_done = 0; m_idx = 0; m_stall = 0;
    end else begin
      if (m_run && !fif.instr_ready && m_stall < 16'hFFFF) m_stall++;
      if (load_we && !m_run) mdl_mem[load_addr] = load_data;
      if (start && !m_run) begin
        m_len   = (int'(prog_len) > 256) ? 256 : int'(prog_len);
        m_idx   = 0;
        m_stall = 0;
        m_run   = (m_len != 0);
        m_done  = (m_len == 0);
      end else if (m_run && fif.instr_ready) begin
        if (m_idx + 1 == m_len) begin
          m_run = 0; m_done = 1;
        end else begin
          m_idx++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(fif.instr_valid), 32'(m_run));
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
`ifdef FETCH_STALL_CNT_EN
      chk("stall", 32'(stall_count), 32'(m_stall));
`else
      chk("stall", 32'(stall_count), 32'h0);
`endif
      if (m_run) begin
        chk("instr", fif.instr_out, mdl_mem[m_idx]);
        chk("pc", fif.pc_out, 32'(m_idx * 4));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(int len);
    prog_len = 9'(len);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'(done), 32'h1);
  endtask

  int hs_cnt;
  logic [31:0] last_pc;

  initial begin
    reset = 1'b1; start = 1'b0; prog_len = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    fif.instr_ready = 1'b1;
    tick();
    tick();
    chk_en = 1;
    @(negedge clk);
    chk("rst_valid", 32'(fif.instr_valid), 32'h0);
    chk("rst_pc", fif.pc_out, 32'h0);
    chk("rst_instr", fif.instr_out, 32'h0);
    reset = 1'b0;
    tick();

    load_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      load_addr = 8'(i);
      load_data = 32'hA5000000 | 32'(i * 257);
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      load_addr = 8'(i);
      load_data = prog[i];
      tick();
    end
    load_we = 1'b0;

    // Full-rate run of the nine-word program
    pulse_start(9);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("t1_instr", fif.instr_out, prog[k]);
      chk("t1_pc", fif.pc_out, 32'(k * 4));
      tick();
    end
    @(negedge clk);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_busy", 32'(busy), 32'h0);
    tick();

    // Consumer stalls on the second instruction
    pulse_start(9);
    tick();
    fif.instr_ready = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("t2_instr", fif.instr_out, 32'h00642842);
    chk("t2_pc", fif.pc_out, 32'h4);
    chk("t2_valid", 32'(fif.instr_valid), 32'h1);
`ifdef FETCH_STALL_CNT_EN
    chk("t2_stall", 32'(stall_count), 32'd3);
`else
    chk("t2_stall", 32'(stall_count), 32'd0);
`endif
    fif.instr_ready = 1'b1;
    wait_done();
    tick();

    // Empty program
    pulse_start(0);
    @(negedge clk);
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_valid", 32'(fif.instr_valid), 32'h0);
    tick(); tick();

    // Start and load while busy are ignored
    pulse_start(9);
    tick();
    start = 1'b1; load_we = 1'b1; load_addr = 8'h0; load_data = 32'hDEADBEEF;
    tick();
    start = 1'b0; load_we = 1'b0;
    wait_done();
    tick();
    pulse_start(9);
    @(negedge clk);
    chk("t4_rerun", fif.instr_out, 32'h00011040);
    wait_done();
    tick();

    // Reset after four handshakes
    pulse_start(9);
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_valid", 32'(fif.instr_valid), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_pc", fif.pc_out, 32'h0);
    reset = 1'b0;
    tick();
    pulse_start(9);
    @(negedge clk);
    chk("t5_instr", fif.instr_out, 32'h00011040);
    wait_done();
    tick();

    // Length clamps to memory depth
    pulse_start(300);
    hs_cnt  = 0;
    last_pc = '0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (fif.instr_valid) begin
        hs_cnt++;
        last_pc = fif.pc_out;
      end
      tick();
    end
    chk("t6_hs", 32'(hs_cnt), 32'd256);
    chk("t6_lastpc", last_pc, 32'h3FC);
    chk("t6_done", 32'(done), 32'h1);
    tick();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
